// File: rtl/decoder_10_to_1024_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decoder_10_to_1024_pipe
// Purpose  : Index-to-vector decoder, the inverse of the 1024:10 priority
//            encoder. It turns a 10-bit index into a 1024-bit one-hot vector
//            and a "strictly above index" thermometer mask. The mask lets the
//            programmable priority path rotate its search start point.
//
//            Two-stage valid/ready pipeline:
//              S1 : split the index into a high group G and a low offset L.
//                   Register four 32-bit pre-decodes:
//                     hi_oh[g] = (g == G)    hi_th[g] = (g > G)
//                     lo_oh[l] = (l == L)    lo_th[l] = (l > L)
//                   When in_en = 0, all four pre-decodes load as 0.
//              S2 : AND/OR merge into the full-width outputs:
//                     onehot[g*32+l]  = hi_oh[g] & lo_oh[l]
//                     mask_hi[g*32+l] = hi_th[g] | (hi_oh[g] & lo_th[l])
//
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            in_valid     input beat present
//            in_ready     block accepts a beat this cycle
//                         (combinational from out_ready; no skid buffer)
//            in_idx       index to decode
//            in_en        1: normal decode; 0: both outputs all-zero
//            out_valid    output beat present
//            out_ready    downstream accepts the output beat
//            out_onehot   only bit in_idx set
//            out_mask_hi  bit j set iff j > in_idx
//
// Revision : 1.0  initial release
// ============================================================================
module decoder_10_to_1024_pipe #(
  parameter int IDX_W = 10,
  parameter int OUT_W = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic [OUT_W-1:0] out_mask_hi
);

  localparam int LO_W = IDX_W / 2;
  localparam int HI_W = IDX_W - LO_W;
  localparam int LO_N = 1 << LO_W;
  localparam int HI_N = 1 << HI_W;

  // --------------------------------------------------------------------------
  // Index split
  // --------------------------------------------------------------------------
  logic [HI_W-1:0] idx_hi;
  logic [LO_W-1:0] idx_lo;

  assign idx_hi = in_idx[IDX_W-1:LO_W];
  assign idx_lo = in_idx[LO_W-1:0];

  // --------------------------------------------------------------------------
  // Stage-1 pre-decode (combinational, gated by in_en)
  // --------------------------------------------------------------------------
  logic [HI_N-1:0] dec_hi_oh;
  logic [HI_N-1:0] dec_hi_th;
  logic [LO_N-1:0] dec_lo_oh;
  logic [LO_N-1:0] dec_lo_th;

  generate
    for (genvar g = 0; g < HI_N; g++) begin : g_hi_dec
      assign dec_hi_oh[g] = in_en & (idx_hi == HI_W'(g));
      assign dec_hi_th[g] = in_en & (HI_W'(g) > idx_hi);
    end

    for (genvar l = 0; l < LO_N; l++) begin : g_lo_dec
      assign dec_lo_oh[l] = in_en & (idx_lo == LO_W'(l));
      assign dec_lo_th[l] = in_en & (LO_W'(l) > idx_lo);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic            s1_valid_q, s1_valid_d;
  logic [HI_N-1:0] hi_oh_q, hi_oh_d;
  logic [HI_N-1:0] hi_th_q, hi_th_d;
  logic [LO_N-1:0] lo_oh_q, lo_oh_d;
  logic [LO_N-1:0] lo_th_q, lo_th_d;

  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] out_onehot_q, out_onehot_d;
  logic [OUT_W-1:0] out_mask_hi_q, out_mask_hi_d;

  // --------------------------------------------------------------------------
  // Stage-2 merge (combinational, from the registered pre-decodes)
  // Within group g, offset l >= 0 lies above the index when the whole group
  // is above G, or when g is the index's own group and l > L.
  // --------------------------------------------------------------------------
  logic [OUT_W-1:0] merge_oh;
  logic [OUT_W-1:0] merge_mk;

  generate
    for (genvar g = 0; g < HI_N; g++) begin : g_merge_hi
      for (genvar l = 0; l < LO_N; l++) begin : g_merge_lo
        assign merge_oh[g*LO_N + l] = hi_oh_q[g] & lo_oh_q[l];
        assign merge_mk[g*LO_N + l] = hi_th_q[g] | (hi_oh_q[g] & lo_th_q[l]);
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Flow control
  // S2 takes the S1 beat when S2 is empty or is draining this cycle.
  // S1 accepts a new beat when it is empty or is handing over to S2, so a
  // full pipe with out_ready = 1 still moves one beat per cycle.
  // --------------------------------------------------------------------------
  logic s1_load;
  logic s2_adv;

  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign s1_load  = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    s1_valid_d    = s1_valid_q;
    hi_oh_d       = hi_oh_q;
    hi_th_d       = hi_th_q;
    lo_oh_d       = lo_oh_q;
    lo_th_d       = lo_th_q;
    s2_valid_d    = s2_valid_q;
    out_onehot_d  = out_onehot_q;
    out_mask_hi_d = out_mask_hi_q;

    // S1: a load wins over a hand-over, so accept-and-drain keeps S1 full.
    if (s1_load) begin
      s1_valid_d = 1'b1;
      hi_oh_d    = dec_hi_oh;
      hi_th_d    = dec_hi_th;
      lo_oh_d    = dec_lo_oh;
      lo_th_d    = dec_lo_th;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // S2: the data registers change only on a load, so a stalled beat stays
    // bit-exact on the outputs.
    if (s2_adv) begin
      s2_valid_d    = 1'b1;
      out_onehot_d  = merge_oh;
      out_mask_hi_d = merge_mk;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      hi_oh_q       <= '0;
      hi_th_q       <= '0;
      lo_oh_q       <= '0;
      lo_th_q       <= '0;
      s2_valid_q    <= 1'b0;
      out_onehot_q  <= '0;
      out_mask_hi_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      hi_oh_q       <= hi_oh_d;
      hi_th_q       <= hi_th_d;
      lo_oh_q       <= lo_oh_d;
      lo_th_q       <= lo_th_d;
      s2_valid_q    <= s2_valid_d;
      out_onehot_q  <= out_onehot_d;
      out_mask_hi_q <= out_mask_hi_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_onehot  = out_onehot_q;
  assign out_mask_hi = out_mask_hi_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_10_to_1024_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_10_to_1024_pipe
// Purpose  : Scoreboard bench for decoder_10_to_1024_pipe.
//            - The driver pushes the expected onehot and mask_hi for each
//              accepted beat.
//            - A negedge monitor pops and compares each delivered beat.
//            - The monitor also checks the invariants and that a stalled beat
//              stays bit-exact on the outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_decoder_10_to_1024_pipe;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [9:0]    in_idx = '0;
  logic          in_en = 1'b0;
  logic          out_valid;
  wire           out_ready;
  logic [1023:0] out_onehot;
  logic [1023:0] out_mask_hi;

  logic rdy_dir  = 1'b0;
  logic rdy_rnd  = 1'b0;
  logic rnd_mode = 1'b0;

  assign out_ready = rnd_mode ? rdy_rnd : rdy_dir;

  always #5 clk = ~clk;

  decoder_10_to_1024_pipe #(.IDX_W(10), .OUT_W(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_mask_hi(out_mask_hi)
  );

  typedef struct {
    logic [9:0]    idx;
    logic          en;
    logic [1023:0] oh;
    logic [1023:0] mk;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure, active only while rnd_mode is set.
  initial begin
    forever begin
      @(posedge clk);
      #1 rdy_rnd = 1'($urandom_range(0, 1));
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic int lsb_of(input logic [1023:0] v);
    for (int i = 0; i < 1024; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk_n(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [1023:0] act, input logic [1023:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual lsb=%0d pop=%0d, required lsb=%0d pop=%0d (t=%0t)",
               name, lsb_of(act), $countones(act), lsb_of(req), $countones(req), $time);
    end
  endtask

  // Independent model for random beats: bit j of the mask is set iff j > idx.
  task automatic model(input logic [9:0] idx, output logic [1023:0] oh, output logic [1023:0] mk);
    oh = '0;
    mk = '0;
    for (int j = 0; j < 1024; j++) begin
      oh[j] = (j == int'(idx));
      mk[j] = (j > int'(idx));
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver: hold the beat until it is accepted, then push its expectation.
  // Entered just after a rising edge.
  // --------------------------------------------------------------------------
  task automatic send(input logic [9:0] idx, input logic en,
                      input logic [1023:0] oh, input logic [1023:0] mk);
    exp_t e;
    int   budget;
    in_idx   = idx;
    in_en    = en;
    in_valid = 1'b1;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.idx = idx;
        e.en  = en;
        e.oh  = oh;
        e.mk  = mk;
        sb.push_back(e);
        @(posedge clk);
        break;
      end
      @(posedge clk);
      budget++;
      if (budget > 1000) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: idx=%0d never accepted", idx);
        break;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    chk_n("drain_remaining", sb.size(), 0);
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic          hold_v = 1'b0;
  logic [1023:0] hold_oh;
  logic [1023:0] hold_mk;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk_n("hold_valid", int'(out_valid), 1);
        chk_w("hold_onehot", out_onehot, hold_oh);
        chk_w("hold_mask", out_mask_hi, hold_mk);
      end
      hold_v = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: lsb=%0d with empty scoreboard", lsb_of(out_onehot));
        end else begin
          e = sb.pop_front();
          pop_cyc.push_back(cyc);
          chk_w("onehot", out_onehot, e.oh);
          chk_w("mask_hi", out_mask_hi, e.mk);
          chk_w("disjoint", out_onehot & out_mask_hi, '0);
          if (e.en) begin
            chk_n("roundtrip_idx", lsb_of(out_onehot), int'(e.idx));
            chk_n("onehot_pop", $countones(out_onehot), 1);
            chk_n("mask_pop", $countones(out_mask_hi), 1023 - int'(e.idx));
            chk_w("mask_formula", out_mask_hi, ~((out_onehot << 1) - 1024'b1) & ~out_onehot);
          end
        end
      end else if (out_valid) begin
        hold_v  = 1'b1;
        hold_oh = out_onehot;
        hold_mk = out_mask_hi;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [1023:0] ones;
  logic [1023:0] r_oh;
  logic [1023:0] r_mk;
  logic [9:0]    r_idx;

  initial begin
    ones = {1024{1'b1}};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_n("rst_out_valid", int'(out_valid), 0);
    chk_n("rst_in_ready", int'(in_ready), 1);
    chk_w("rst_onehot", out_onehot, '0);
    chk_w("rst_mask", out_mask_hi, '0);
    @(posedge clk);
    #1;

    // 1. idx=0, single beat, one-cycle pulse on out_valid
    rdy_dir = 1'b1;
    send(10'd0, 1'b1, 1024'b1, ~1024'b1);
    @(negedge clk);
    chk_n("t1_valid_e1", int'(out_valid), 0);
    @(negedge clk);
    chk_n("t1_valid_e2", int'(out_valid), 1);
    @(negedge clk);
    chk_n("t1_valid_e3", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // 2. Group boundaries back-to-back; the beats must land on consecutive cycles
    pop_cyc.delete();
    send(10'd1023, 1'b1, 1024'b1 << 1023, '0);
    send(10'd31,   1'b1, 1024'b1 << 31,   ones << 32);
    send(10'd32,   1'b1, 1024'b1 << 32,   ones << 33);
    send(10'd37,   1'b1, 1024'b1 << 37,   ones << 38);
    wait_drain();
    chk_n("t2_beats", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++) chk_n("t2_consecutive", pop_cyc[i] - pop_cyc[i-1], 1);
    @(posedge clk);
    #1;

    // 3. Backpressure: two beats fill the pipe, then in_ready drops
    rdy_dir = 1'b0;
    fork
      begin
        send(10'd5, 1'b1, 1024'b1 << 5, ones << 6);
        send(10'd6, 1'b1, 1024'b1 << 6, ones << 7);
        send(10'd7, 1'b1, 1024'b1 << 7, ones << 8);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_n("t3_in_ready_low", int'(in_ready), 0);
        chk_n("t3_out_valid", int'(out_valid), 1);
        repeat (2) @(posedge clk);
        #1 rdy_dir = 1'b1;
      end
    join
    wait_drain();
    @(posedge clk);
    #1;

    // 4. in_en=0: a valid beat with both vectors zero
    send(10'd100, 1'b0, '0, '0);
    wait_drain();
    @(posedge clk);
    #1;

    // 5. Reset with both stages full
    rdy_dir = 1'b0;
    send(10'd300, 1'b1, 1024'b1 << 300, ones << 301);
    send(10'd301, 1'b1, 1024'b1 << 301, ones << 302);
    #1 rst_n = 1'b0;
    #1;
    chk_n("t5_rst_valid", int'(out_valid), 0);
    chk_w("t5_rst_onehot", out_onehot, '0);
    chk_w("t5_rst_mask", out_mask_hi, '0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_dir = 1'b1;
    send(10'd200, 1'b1, 1024'b1 << 200, ones << 201);
    wait_drain();
    @(posedge clk);
    #1;

    // 6. Random indices with random backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r_idx = 10'($urandom_range(0, 1023));
      model(r_idx, r_oh, r_mk);
      send(r_idx, 1'b1, r_oh, r_mk);
    end
    wait_drain();
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
